alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - Microcoded strobe sequencer driving a single-bus ALU datapath

module alu_op_sequencer #(
    parameter int              NREG   = 16,
    parameter int              IDX_W  = 4,
    parameter int              OP_W   = 5,
    parameter logic [OP_W-1:0] OP_MUL = 5'b01111,
    parameter logic [OP_W-1:0] OP_DIV = 5'b10000,
    parameter logic [OP_W-1:0] OP_NEG = 5'b10001,
    parameter logic [OP_W-1:0] OP_NOT = 5'b10010
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [IDX_W-1:0]  src_a,
    input  logic [IDX_W-1:0]  src_b,
    input  logic [IDX_W-1:0]  dst,
    output logic [NREG-1:0]   reg_out,
    output logic [NREG-1:0]   reg_in,
    output logic              ry_in,
    output logic              ry_out,
    output logic              rz_in,
    output logic              rzlo_out,
    output logic              rzhi_out,
    output logic              hi_in,
    output logic              lo_in,
    output logic [OP_W-1:0]   alu_op,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t             state, state_nx;
    logic [OP_W-1:0]    op_q, op_nx;
    logic [IDX_W-1:0]   a_q, a_nx;
    logic [IDX_W-1:0]   b_q, b_nx;
    logic [IDX_W-1:0]   d_q, d_nx;

    logic               unary_nx;
    logic               wide_nx;

    logic [NREG-1:0]    reg_out_nx;
    logic [NREG-1:0]    reg_in_nx;
    logic               ry_in_nx;
    logic               ry_out_nx;
    logic               rz_in_nx;
    logic               rzlo_out_nx;
    logic               rzhi_out_nx;
    logic               hi_in_nx;
    logic               lo_in_nx;
    logic [OP_W-1:0]    alu_op_nx;
    logic               busy_nx;
    logic               done_nx;

    // Indices beyond the register file decode to no enable at all.
    function automatic logic [NREG-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == IDX_W'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic is_unary(input logic [OP_W-1:0] code);
        return (code == OP_NEG) || (code == OP_NOT);
    endfunction

    function automatic logic is_wide(input logic [OP_W-1:0] code);
        return (code == OP_MUL) || (code == OP_DIV);
    endfunction

    // Next state and operand latch; fields only load on an accepted start in IDLE.
    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        a_nx     = a_q;
        b_nx     = b_q;
        d_nx     = d_q;
        case (state)
            IDLE: begin
                if (start) begin
                    op_nx    = op;
                    a_nx     = src_a;
                    b_nx     = src_b;
                    d_nx     = dst;
                    state_nx = is_unary(op) ? T1 : T0;
                end
            end
            T0:      state_nx = T1;
            T1:      state_nx = T2;
            T2:      state_nx = is_wide(op_q) ? T3 : DONE;
            T3:      state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobe decode for the state about to be entered, so outputs come straight from flops.
    always_comb begin
        unary_nx    = is_unary(op_nx);
        wide_nx     = is_wide(op_nx);
        reg_out_nx  = '0;
        reg_in_nx   = '0;
        ry_in_nx    = 1'b0;
        ry_out_nx   = 1'b0;
        rz_in_nx    = 1'b0;
        rzlo_out_nx = 1'b0;
        rzhi_out_nx = 1'b0;
        hi_in_nx    = 1'b0;
        lo_in_nx    = 1'b0;
        alu_op_nx   = '0;
        busy_nx     = (state_nx != IDLE);
        done_nx     = 1'b0;
        case (state_nx)
            T0: begin
                reg_out_nx = onehot(a_nx);
                ry_in_nx   = 1'b1;
            end
            T1: begin
                alu_op_nx = op_nx;
                rz_in_nx  = 1'b1;
                if (unary_nx) begin
                    reg_out_nx = onehot(a_nx);
                end else begin
                    reg_out_nx = onehot(b_nx);
                    ry_out_nx  = 1'b1;
                end
            end
            T2: begin
                rzlo_out_nx = 1'b1;
                if (wide_nx) begin
                    lo_in_nx = 1'b1;
                end else begin
                    reg_in_nx = onehot(d_nx);
                end
            end
            T3: begin
                rzhi_out_nx = 1'b1;
                hi_in_nx    = 1'b1;
            end
            DONE:    done_nx = 1'b1;
            default: ;
        endcase
    end

    // State, latched fields and registered strobes; clear aborts any operation at once.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            reg_out  <= '0;
            reg_in   <= '0;
            ry_in    <= 1'b0;
            ry_out   <= 1'b0;
            rz_in    <= 1'b0;
            rzlo_out <= 1'b0;
            rzhi_out <= 1'b0;
            hi_in    <= 1'b0;
            lo_in    <= 1'b0;
            alu_op   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            op_q     <= op_nx;
            a_q      <= a_nx;
            b_q      <= b_nx;
            d_q      <= d_nx;
            reg_out  <= reg_out_nx;
            reg_in   <= reg_in_nx;
            ry_in    <= ry_in_nx;
            ry_out   <= ry_out_nx;
            rz_in    <= rz_in_nx;
            rzlo_out <= rzlo_out_nx;
            rzhi_out <= rzhi_out_nx;
            hi_in    <= hi_in_nx;
            lo_in    <= lo_in_nx;
            alu_op   <= alu_op_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

endmodule
